dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory read/write port between two requesters: the CPU load/store unit (`cpu_*`) and an auxiliary master (`aux_*`, e.g. boot loader or debug/DMA).
- Fixed priority to the CPU, with a starvation limit that forces an aux grant.
- Supports a CPU lock so an ARMv4 SWP read-modify-write is atomic.
- Sits between the core/aux masters and the data memory (memory reads on posedge `clk`, writes on negedge `clk`).

Parameters:
- `bus`, 32, data/address width.
- `STARVE_MAX`, 4, number of consecutive cycles aux may be denied before it is forced to win; must be ≥ 1.

Ports:
- `clk`  input  1  system clock; the same clock as the data memory `clk`
- `rst`  input  1  reset, asynchronous, active-high
- `cpu_req`  input  1  CPU access request; held until `cpu_gnt`
- `cpu_we`  input  1  1 = write, 0 = read
- `cpu_lock`  input  1  keep ownership after this access (SWP)
- `cpu_addr`  input  bus  byte address
- `cpu_wdata`  input  bus  write data
- `cpu_gnt`  output  1  access accepted this cycle
- `cpu_rvalid`  output  1  `mem_rdata` is the CPU's read result
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`: same directions, widths and meaning as the `cpu_*` ports (no lock)
- `mem_addr`  output  bus  word-aligned address to memory
- `mem_wdata`  output  bus  write data to memory
- `mem_re`  output  1  memory read enable (MRE)
- `mem_we`  output  1  memory write enable (MWE)
- `mem_rdata`  input  bus  memory registered read data

Behaviour:
- Interface:
  - One clock, `clk`.
  - `rst` is asynchronous, active-high; all state is cleared immediately on assertion.
- Reset values:
  - state = IDLE, starve_cnt = 0, `cpu_rvalid` = 0, `aux_rvalid` = 0.
  - All grants and `mem_re`/`mem_we` are 0 while `rst` is high.
- Grants are combinational from the current state and requests. At most one grant is issued per cycle.
- Grant rule in IDLE:
  - If starve_cnt == STARVE_MAX and `aux_req`: grant aux.
  - Else if `cpu_req`: grant cpu.
  - Else if `aux_req`: grant aux.
  - Else: no grant.
- Grant rule in LOCKED: only cpu may be granted; `aux_gnt` = 0.
- Memory drive:
  - `mem_addr` = {granted addr[bus-1:2], 2'b00}.
  - `mem_wdata` = granted wdata.
  - `mem_we` = gnt & we; `mem_re` = gnt & ~we.
  - With no grant, `mem_re`/`mem_we` = 0 and `mem_addr`/`mem_wdata` = 0.
- Read latency: 1 cycle.
  - `x_rvalid` is registered: it equals 1 in the cycle after a read grant to x, else 0.
  - The requester samples `mem_rdata` while `x_rvalid` = 1.
- Writes complete at the grant cycle; there is no write response.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, in each cycle where `aux_req` = 1 and `aux_gnt` = 0.
  - Clears on `aux_gnt` or when `aux_req` = 0.
- State machine:
  - IDLE → LOCKED on `cpu_gnt` with `cpu_lock` = 1.
  - LOCKED → IDLE on `cpu_gnt` with `cpu_lock` = 0.
  - LOCKED → IDLE if `cpu_req` = 0 and `cpu_lock` = 0 (lock abandoned).
  - LOCKED otherwise holds.
- Starvation never preempts LOCKED. starve_cnt keeps saturating at STARVE_MAX there, so aux wins the first IDLE cycle.
- Simultaneous requests in IDLE with starve_cnt < STARVE_MAX: cpu wins.
- `rst` asserted mid-access: any pending `rvalid` is dropped and the lock is released. A requester must reissue.

Optional Feature:
- Macro `DMEM_ARB_STATS_EN`.
- Defined:
  - Adds outputs `stat_cpu_grants`, `stat_aux_grants` and `stat_conflicts`, each 16 bits.
  - `stat_cpu_grants` / `stat_aux_grants` count grants per requester.
  - `stat_conflicts` counts cycles in which both requests are high.
  - All three saturate at 16'hFFFF and clear on `rst`.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package `dmem_arb_pkg`:
  - State enum `arb_state_t` {IDLE, LOCKED}.
  - Owner enum `arb_owner_t` {OWN_NONE, OWN_CPU, OWN_AUX}.
  - Constant `STAT_W` = 16.
- One sub-module, `dmem_arb_starve`: the saturating starvation counter with a `force_aux` output. Everything else stays in `dmem_arbiter`.

Test Plan:
- CPU read at 0x0000_0104 alone → `cpu_gnt` = 1 the same cycle, `mem_addr` = 0x104, `mem_re` = 1, `cpu_rvalid` = 1 next cycle with `mem_rdata`.
- CPU and aux both requesting continuously with STARVE_MAX = 4 → cpu granted 4 cycles, aux granted on the 5th; pattern repeats every 5 cycles.
- CPU SWP: read with `cpu_lock` = 1 at 0x200, then write 0xDEADBEEF with `cpu_lock` = 0, while aux requests throughout → `aux_gnt` = 0 until the write is granted, then aux is granted the next cycle.
- Aux write 0x12345678 to address 0x00000007 → `mem_addr` = 0x4, `mem_we` = 1, `aux_rvalid` stays 0.
- Assert `rst` asynchronously in the cycle after a cpu read grant → `cpu_rvalid` drops to 0 immediately, state = IDLE, starve_cnt = 0.
- With `DMEM_ARB_STATS_EN`, 10 cycles of dual requests (STARVE_MAX = 4) → `stat_conflicts` = 10, `stat_cpu_grants` = 8, `stat_aux_grants` = 2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the data-memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, LOCKED for an atomic SWP sequence)
//   arb_owner_t : which requester owns the memory port in the current cycle
//   STAT_W      : width of the optional statistics counters
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } arb_owner_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_arb_starve.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve
//   Saturating starvation counter for the auxiliary requester. Counts
//   consecutive cycles in which aux requests but is not granted; once it
//   reaches STARVE_MAX, force_aux tells the arbiter to hand the port to aux.
//   STARVE_MAX must be at least 1.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   aux_req   in   aux request
//   aux_gnt   in   aux grant issued this cycle
//   force_aux out  counter saturated; aux must win the next IDLE arbitration
// -----------------------------------------------------------------------------
module dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic aux_req,
  input  logic aux_gnt,
  output logic force_aux
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  // Holds at CNT_MAX while aux stays denied (e.g. across a LOCKED sequence),
  // so aux wins the first cycle back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (aux_req && !aux_gnt) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign force_aux = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the CPU load/store unit and an
//   auxiliary master. Fixed priority to the CPU, with a starvation limit that
//   forces an aux grant, and a CPU lock that keeps the port through an SWP
//   read-modify-write. Grants are combinational; read valid is registered one
//   cycle after a read grant (memory read data is registered on posedge clk).
//
// Optional feature (macro DMEM_ARB_STATS_EN): adds 16-bit saturating grant and
//   conflict counters stat_cpu_grants, stat_aux_grants, stat_conflicts.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_req/we/lock/addr/wdata CPU request (lock keeps ownership after access)
//   cpu_gnt, cpu_rvalid        CPU grant, CPU read data valid on mem_rdata
//   aux_req/we/addr/wdata      aux request
//   aux_gnt, aux_rvalid        aux grant, aux read data valid on mem_rdata
//   mem_addr/wdata/re/we       memory port drive (word-aligned address)
//   mem_rdata                  memory registered read data (routed to masters
//                              externally; only the valids come from here)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int bus        = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic           cpu_lock,
  input  logic [bus-1:0] cpu_addr,
  input  logic [bus-1:0] cpu_wdata,
  output logic           cpu_gnt,
  output logic           cpu_rvalid,
  input  logic           aux_req,
  input  logic           aux_we,
  input  logic [bus-1:0] aux_addr,
  input  logic [bus-1:0] aux_wdata,
  output logic           aux_gnt,
  output logic           aux_rvalid,
  output logic [bus-1:0] mem_addr,
  output logic [bus-1:0] mem_wdata,
  output logic           mem_re,
  output logic           mem_we,
  input  logic [bus-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_aux_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  logic       force_aux;

  // Read data and the low address bits never influence arbitration.
  logic unused_bits;
  assign unused_bits = ^{mem_rdata, cpu_addr[1:0], aux_addr[1:0]};

  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .aux_req   (aux_req),
    .aux_gnt   (aux_gnt),
    .force_aux (force_aux)
  );

  // Stage 0: combinational arbitration and memory drive
  always_comb begin
    owner = OWN_NONE;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (force_aux && aux_req) begin
            owner = OWN_AUX;
          end else if (cpu_req) begin
            owner = OWN_CPU;
          end else if (aux_req) begin
            owner = OWN_AUX;
          end
        end
        LOCKED: begin
          // Starvation never breaks an atomic sequence.
          if (cpu_req) begin
            owner = OWN_CPU;
          end
        end
        default: owner = OWN_NONE;
      endcase
    end
  end

  assign cpu_gnt = (owner == OWN_CPU);
  assign aux_gnt = (owner == OWN_AUX);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (owner)
      OWN_CPU: begin
        mem_addr  = {cpu_addr[bus-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_re    = ~cpu_we;
        mem_we    = cpu_we;
      end
      OWN_AUX: begin
        mem_addr  = {aux_addr[bus-1:2], 2'b00};
        mem_wdata = aux_wdata;
        mem_re    = ~aux_we;
        mem_we    = aux_we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_gnt && cpu_lock) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Leave on the final unlocked access, or if the CPU drops the lock
        // without issuing it.
        if ((cpu_gnt && !cpu_lock) || (!cpu_req && !cpu_lock)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage 1: read valid, aligned with the memory's registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      aux_rvalid <= aux_gnt & ~aux_we;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    logic [STAT_W-1:0] r;
    r = v;
    if (en && (v != {STAT_W{1'b1}})) begin
      r = v + STAT_W'(1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cpu_grants <= '0;
      stat_aux_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      stat_cpu_grants <= sat_inc(stat_cpu_grants, cpu_gnt);
      stat_aux_grants <= sat_inc(stat_aux_grants, aux_gnt);
      stat_conflicts  <= sat_inc(stat_conflicts, cpu_req & aux_req);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_lock;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_gnt, aux_rvalid;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu_grants, stat_aux_grants, stat_conflicts;
`endif

  dmem_arbiter #(.bus(32), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_cpu_grants (stat_cpu_grants),
    .stat_aux_grants (stat_aux_grants),
    .stat_conflicts  (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: registered read of a fixed address-derived pattern.
  function automatic logic [31:0] mem_pat(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_pat(mem_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_cpu;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  // Reference model state
  bit m_locked = 0;
  int m_cnt    = 0;

  task automatic model_reset();
    m_locked = 0;
    m_cnt    = 0;
    rd_q.delete();
  endtask

  // One clock cycle: drive at negedge, check just after, then advance model.
  task automatic tick(input bit creq, input bit cwe, input bit clk_lock,
                      input logic [31:0] caddr, input logic [31:0] cwd,
                      input bit areq, input bit awe,
                      input logic [31:0] aaddr, input logic [31:0] awd);
    bit cg, ag;
    logic [31:0] e_addr, e_wd;
    bit e_re, e_we;
    rd_exp_t e;
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_lock = clk_lock; cpu_addr = caddr; cpu_wdata = cwd;
    aux_req = areq; aux_we = awe; aux_addr = aaddr; aux_wdata = awd;
    cg = 0; ag = 0;
    if (m_locked) cg = creq;
    else if (m_cnt == 4 && areq) ag = 1;
    else if (creq) cg = 1;
    else if (areq) ag = 1;
    e_addr = 0; e_wd = 0; e_re = 0; e_we = 0;
    if (cg) begin e_addr = {caddr[31:2], 2'b00}; e_wd = cwd; e_re = !cwe; e_we = cwe; end
    if (ag) begin e_addr = {aaddr[31:2], 2'b00}; e_wd = awd; e_re = !awe; e_we = awe; end
    #1;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(e.is_cpu));
      check("aux_rvalid", 32'(aux_rvalid), 32'(!e.is_cpu));
      check("rdata", mem_rdata, e.data);
    end else begin
      check("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
      check("aux_rvalid_idle", 32'(aux_rvalid), 32'd0);
    end
    check("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    check("aux_gnt", 32'(aux_gnt), 32'(ag));
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    if (e_re) begin
      e.is_cpu = cg;
      e.data   = mem_pat(e_addr);
      rd_q.push_back(e);
    end
    if (areq && !ag) m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    else m_cnt = 0;
    if (!m_locked) begin
      if (cg && clk_lock) m_locked = 1;
    end else if ((cg && !clk_lock) || (!creq && !clk_lock)) begin
      m_locked = 0;
    end
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1;
    cpu_req = 1; cpu_we = 0; cpu_lock = 0; cpu_addr = 32'h40; cpu_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
    mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
    @(negedge clk);
    rst = 0; cpu_req = 0;
    model_reset();

    // Continuous dual requests: four cpu grants, then aux, repeating.
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 32'h1000 + 32'(i * 4), 0, 1, 0, 32'h2000 + 32'(i * 4), 0);
      check("pattern_aux", 32'(aux_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
`ifdef DMEM_ARB_STATS_EN
    @(posedge clk);
    #1;
    check("stat_conflicts", 32'(stat_conflicts), 32'd10);
    check("stat_cpu_grants", 32'(stat_cpu_grants), 32'd8);
    check("stat_aux_grants", 32'(stat_aux_grants), 32'd2);
`endif
    idle_tick();

    // Lone CPU read at 0x104.
    tick(1, 0, 0, 32'h0000_0104, 0, 0, 0, 0, 0);
    check("t1_addr", mem_addr, 32'h104);
    check("t1_re", 32'(mem_re), 32'd1);
    idle_tick();
    check("t1_rdata", mem_rdata, 32'h5A5A_0104);
    check("t1_rvalid", 32'(cpu_rvalid), 32'd1);

    // SWP: locked read, gap, unlocked write; aux requests throughout.
    tick(1, 0, 1, 32'h200, 0, 1, 0, 32'h300, 0);
    check("swp_rd_gnt", 32'(cpu_gnt), 32'd1);
    tick(0, 0, 1, 32'h200, 0, 1, 0, 32'h300, 0);
    check("swp_hold_aux", 32'(aux_gnt), 32'd0);
    tick(1, 1, 0, 32'h200, 32'hDEAD_BEEF, 1, 0, 32'h300, 0);
    check("swp_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("swp_wr_aux", 32'(aux_gnt), 32'd0);
    tick(0, 0, 0, 0, 0, 1, 0, 32'h300, 0);
    check("swp_aux_after", 32'(aux_gnt), 32'd1);
    idle_tick();

    // Aux write to an unaligned address.
    tick(0, 0, 0, 0, 0, 1, 1, 32'h0000_0007, 32'h1234_5678);
    check("aux_wr_addr", mem_addr, 32'h4);
    check("aux_wr_we", 32'(mem_we), 32'd1);
    idle_tick();
    check("aux_wr_norv", 32'(aux_rvalid), 32'd0);

    // Async reset the cycle after a locked CPU read grant.
    tick(1, 0, 1, 32'h300, 0, 1, 0, 32'h500, 0);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("arst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("arst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("arst_mem_re", 32'(mem_re), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cpu_req = 0; cpu_lock = 0; aux_req = 0;
    // Lock released: aux alone wins immediately.
    tick(0, 0, 0, 0, 0, 1, 0, 32'h500, 0);
    check("arst_idle_aux", 32'(aux_gnt), 32'd1);
    // Counter cleared: cpu wins four dual cycles before aux.
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 32'h600, 0, 1, 1, 32'h700, 32'h77);
      check("arst_cnt_aux", 32'(aux_gnt), (i == 4) ? 32'd1 : 32'd0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    idle_tick();
    idle_tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
